// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC control path: opcodes, FSM states and
// instruction field positions.
package sisc_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned FUNC_W  = 4;
    localparam int unsigned REG_AW  = 4;
    localparam int unsigned STAT_W  = 4;

    // Instruction field LSB positions
    localparam int unsigned OPC_LSB  = 28;
    localparam int unsigned FUNC_LSB = 24;
    localparam int unsigned RD_LSB   = 20;
    localparam int unsigned RS_LSB   = 16;
    localparam int unsigned RT_LSB   = 12;
    localparam int unsigned IMM_LSB  = 0;
    localparam int unsigned IMM_W    = 16;

    localparam logic [REG_AW-1:0] R0 = 4'd0;

    localparam logic [OPC_W-1:0] OP_NOP    = 4'h0;
    localparam logic [OPC_W-1:0] OP_ALU    = 4'h1;
    localparam logic [OPC_W-1:0] OP_ALUI   = 4'h2;
    localparam logic [OPC_W-1:0] OP_LOAD   = 4'h3;
    localparam logic [OPC_W-1:0] OP_STORE  = 4'h4;
    localparam logic [OPC_W-1:0] OP_BRANCH = 4'h5;
    localparam logic [OPC_W-1:0] OP_JUMP   = 4'h6;
    localparam logic [OPC_W-1:0] OP_HALT   = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

endpackage

// File: rtl/sisc_ctrl_branch.sv
// Branch condition: taken when func is zero (unconditional) or any selected
// ALU flag is set.
module sisc_ctrl_branch
    import sisc_pkg::*;
(
    input  logic [FUNC_W-1:0] func,
    input  logic [STAT_W-1:0] stat,
    output logic              taken
);

    assign taken = (func == '0) | (|(stat & func));

endmodule

// File: rtl/sisc_ctrl.sv
// Multi-cycle SISC control sequencer. Define SISC_CTRL_MEM_WAIT_EN to stall
// the MEM state on mem_ready.
module sisc_ctrl
    import sisc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic                clk,
    input  logic                rst_f,
    input  logic [INSTR_W-1:0]  instr,
    input  logic [STAT_W-1:0]   stat,
    input  logic                mem_ready,
    output logic [REG_AW-1:0]   read_rega,
    output logic [REG_AW-1:0]   read_regb,
    output logic [REG_AW-1:0]   write_reg,
    output logic                rf_we,
    output logic                wb_sel,
    output logic [FUNC_W-1:0]   alu_op,
    output logic                alu_imm,
    output logic                ir_load,
    output logic                pc_write,
    output logic                pc_sel,
    output logic                pc_rst_load,
    output logic [31:0]         pc_init,
    output logic                mem_read,
    output logic                mem_write,
    output logic                halted
);

    state_e              state;
    state_e              state_nxt;
    logic [INSTR_W-1:0]  ir;

    logic [OPC_W-1:0]    opc;
    logic [FUNC_W-1:0]   func;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   rs;
    logic [REG_AW-1:0]   rt;
    logic                taken;
    logic                mem_go;
    logic                unused_bits;

    assign opc  = ir[OPC_LSB  +: OPC_W];
    assign func = ir[FUNC_LSB +: FUNC_W];
    assign rd   = ir[RD_LSB   +: REG_AW];
    assign rs   = ir[RS_LSB   +: REG_AW];
    assign rt   = ir[RT_LSB   +: REG_AW];

    sisc_ctrl_branch u_branch (
        .func  (func),
        .stat  (stat),
        .taken (taken)
    );

    // Low immediate bits feed the datapath only, never the sequencer.
`ifdef SISC_CTRL_MEM_WAIT_EN
    assign mem_go      = mem_ready;
    assign unused_bits = ^ir[RT_LSB-1:IMM_LSB];
`else
    assign mem_go      = 1'b1;
    assign unused_bits = ^{mem_ready, ir[RT_LSB-1:IMM_LSB]};
`endif

    // State and instruction register are the only flops.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state <= ST_FETCH;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_FETCH) begin
                ir <= instr;
            end
        end
    end

    // Next state and control decode; everything is forced quiet while reset is held.
    always_comb begin
        state_nxt   = state;
        read_rega   = R0;
        read_regb   = R0;
        write_reg   = R0;
        rf_we       = 1'b0;
        wb_sel      = 1'b0;
        alu_op      = '0;
        alu_imm     = 1'b0;
        ir_load     = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = 1'b0;
        pc_rst_load = 1'b0;
        pc_init     = RESET_PC;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        halted      = 1'b0;

        if (!rst_f) begin
            state_nxt   = ST_FETCH;
            pc_rst_load = 1'b1;
        end else begin
            // Read addresses stay put from DECODE to the end of the instruction.
            if (state inside {ST_DECODE, ST_EXECUTE, ST_MEM, ST_WRITEBACK}) begin
                read_rega = rs;
                if (opc == OP_ALU || opc == OP_BRANCH) begin
                    read_regb = rt;
                end else if (opc == OP_STORE) begin
                    read_regb = rd;
                end
            end

            case (state)
                ST_FETCH: begin
                    ir_load   = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = ST_DECODE;
                end
                ST_DECODE: begin
                    case (opc)
                        OP_HALT:   state_nxt = ST_HALT;
                        OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JUMP:
                                   state_nxt = ST_EXECUTE;
                        default:   state_nxt = ST_FETCH;
                    endcase
                end
                ST_EXECUTE: begin
                    alu_op    = func;
                    alu_imm   = (opc == OP_ALUI) || (opc == OP_LOAD) || (opc == OP_STORE);
                    state_nxt = ST_FETCH;
                    case (opc)
                        OP_ALU, OP_ALUI:  state_nxt = ST_WRITEBACK;
                        OP_LOAD, OP_STORE: state_nxt = ST_MEM;
                        OP_BRANCH: begin
                            pc_write = taken;
                            pc_sel   = taken;
                        end
                        OP_JUMP: begin
                            pc_write = 1'b1;
                            pc_sel   = 1'b1;
                        end
                        default: state_nxt = ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    mem_read  = (opc == OP_LOAD);
                    mem_write = (opc == OP_STORE);
                    if (mem_go) begin
                        state_nxt = (opc == OP_LOAD) ? ST_WRITEBACK : ST_FETCH;
                    end
                end
                ST_WRITEBACK: begin
                    write_reg = rd;
                    wb_sel    = (opc == OP_LOAD);
                    rf_we     = (rd != R0);
                    state_nxt = ST_FETCH;
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: state_nxt = ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_sisc_ctrl.sv
// Scoreboard bench for sisc_ctrl: per-cycle expected controls are queued
// from an instruction-level model and compared each cycle.
`timescale 1ns/1ps
module tb_sisc_ctrl;

    typedef struct packed {
        logic [3:0] rega;
        logic [3:0] regb;
        logic [3:0] wreg;
        logic       rf_we;
        logic       wb_sel;
        logic [3:0] alu_op;
        logic       alu_imm;
        logic       ir_load;
        logic       pc_write;
        logic       pc_sel;
        logic       pc_rst_load;
        logic       mem_read;
        logic       mem_write;
        logic       halted;
    } ov_t;

    typedef struct {
        string tag;
        logic  mem_ready;
        ov_t   exp;
        ov_t   mask;
    } step_t;

    logic        clk;
    logic        rst_f;
    logic [31:0] instr;
    logic [3:0]  stat;
    logic        mem_ready;
    logic [3:0]  read_rega, read_regb, write_reg, alu_op;
    logic        rf_we, wb_sel, alu_imm, ir_load, pc_write, pc_sel;
    logic        pc_rst_load, mem_read, mem_write, halted;
    logic [31:0] pc_init;

    int checks   = 0;
    int failures = 0;
    step_t sb[$];

`ifdef SISC_CTRL_MEM_WAIT_EN
    localparam logic MR_IDLE = 1'b1;
`else
    localparam logic MR_IDLE = 1'b0;
`endif

    sisc_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_f       (rst_f),
        .instr       (instr),
        .stat        (stat),
        .mem_ready   (mem_ready),
        .read_rega   (read_rega),
        .read_regb   (read_regb),
        .write_reg   (write_reg),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .alu_op      (alu_op),
        .alu_imm     (alu_imm),
        .ir_load     (ir_load),
        .pc_write    (pc_write),
        .pc_sel      (pc_sel),
        .pc_rst_load (pc_rst_load),
        .pc_init     (pc_init),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ov_t cur_out();
        ov_t o;
        o.rega = read_rega;   o.regb = read_regb;     o.wreg = write_reg;
        o.rf_we = rf_we;      o.wb_sel = wb_sel;      o.alu_op = alu_op;
        o.alu_imm = alu_imm;  o.ir_load = ir_load;    o.pc_write = pc_write;
        o.pc_sel = pc_sel;    o.pc_rst_load = pc_rst_load;
        o.mem_read = mem_read; o.mem_write = mem_write; o.halted = halted;
        return o;
    endfunction

    // Every single-bit control is checked on every cycle.
    function automatic ov_t strobe_mask();
        ov_t m = '0;
        m.rf_we = 1'b1;   m.wb_sel = 1'b1;   m.alu_imm = 1'b1;  m.ir_load = 1'b1;
        m.pc_write = 1'b1; m.pc_sel = 1'b1;  m.pc_rst_load = 1'b1;
        m.mem_read = 1'b1; m.mem_write = 1'b1; m.halted = 1'b1;
        return m;
    endfunction

    task automatic push(input string tag, input logic mr, input ov_t e, input ov_t m);
        step_t s;
        s.tag = tag; s.mem_ready = mr; s.exp = e; s.mask = m;
        sb.push_back(s);
    endtask

    // Instruction-level reference: queue the expected control trace.
    task automatic gen(input logic [31:0] ins, input logic [3:0] st, input int nwait, input string name);
        logic [3:0] op, fn, rd, rs, rt;
        ov_t e, a, m, ma;
        logic br_taken;
        int nmem;
        op = ins[31:28]; fn = ins[27:24]; rd = ins[23:20]; rs = ins[19:16]; rt = ins[15:12];
        m = strobe_mask();

        e = '0; e.ir_load = 1'b1; e.pc_write = 1'b1;
        push({name, "_fetch"}, MR_IDLE, e, m);

        a = '0; a.rega = rs;
        ma = m; ma.rega = 4'hF;
        if (op == 4'h1 || op == 4'h5) begin a.regb = rt; ma.regb = 4'hF; end
        if (op == 4'h4)               begin a.regb = rd; ma.regb = 4'hF; end
        push({name, "_decode"}, MR_IDLE, a, ma);
        if (op == 4'h0 || op > 4'h6) return;

        e = a; e.alu_op = fn; e.alu_imm = (op >= 4'h2 && op <= 4'h4);
        br_taken = (fn == 4'h0) || ((st & fn) != 4'h0);
        if (op == 4'h6 || (op == 4'h5 && br_taken)) begin e.pc_write = 1'b1; e.pc_sel = 1'b1; end
        m = ma; m.alu_op = 4'hF;
        push({name, "_exec"}, MR_IDLE, e, m);
        if (op >= 4'h5) return;

        if (op == 4'h3 || op == 4'h4) begin
`ifdef SISC_CTRL_MEM_WAIT_EN
            nmem = nwait + 1;
`else
            nmem = 1;
`endif
            for (int i = 0; i < nmem; i++) begin
                e = a; e.mem_read = (op == 4'h3); e.mem_write = (op == 4'h4);
`ifdef SISC_CTRL_MEM_WAIT_EN
                push({name, "_mem"}, (i == nwait), e, ma);
`else
                push({name, "_mem"}, 1'b0, e, ma);
`endif
            end
            if (op == 4'h4) return;
        end

        e = a; e.wreg = rd; e.wb_sel = (op == 4'h3); e.rf_we = (rd != 4'h0);
        m = ma; m.wreg = 4'hF;
        push({name, "_wb"}, MR_IDLE, e, m);
    endtask

    task automatic run_steps(input int n);
        int k = 0;
        while (sb.size() > 0 && (n < 0 || k < n)) begin
            step_t s;
            s = sb.pop_front();
            mem_ready = s.mem_ready;
            #1;
            check(s.tag, 32'(cur_out() & s.mask), 32'(s.exp & s.mask));
            @(negedge clk);
            k++;
        end
    endtask

    task automatic do_instr(input logic [31:0] ins, input logic [3:0] st, input int nwait, input string name);
        instr = ins;
        stat  = st;
        gen(ins, st, nwait, name);
        run_steps(-1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        ov_t rv, hv;
        rv = '0; rv.pc_rst_load = 1'b1;
        hv = '0; hv.halted = 1'b1;

        rst_f = 1'b0; instr = 32'h1312_0000; stat = 4'h0; mem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("reset_hold", 32'(cur_out()), 32'(rv));
        end
        check("pc_init", pc_init, 32'h0000_0000);
        @(negedge clk);
        rst_f = 1'b1;

        do_instr(32'h1312_0000, 4'h0, 0, "alu_rr");
        do_instr(32'h2004_0005, 4'h0, 0, "alui_r0");
        do_instr(32'h2A71_0003, 4'h0, 0, "alui");
        do_instr(32'h5100_0010, 4'b0001, 0, "br_taken");
        do_instr(32'h5100_0010, 4'b0000, 0, "br_not");
        do_instr(32'h5000_0020, 4'b0000, 0, "br_uncond");
        do_instr(32'h6000_0000, 4'b0000, 0, "jump");
        do_instr(32'h7123_0000, 4'h0, 0, "unk_op");
        do_instr(32'h0000_0000, 4'h0, 0, "nop");
        do_instr(32'h4A30_0008, 4'h0, 3, "store_wait");
        do_instr(32'h3051_0004, 4'h0, 0, "load");
        do_instr(32'h3052_0004, 4'h0, 2, "load_wait");
        do_instr(32'hF000_0000, 4'h0, 0, "halt");

        instr = 32'h1312_0000;
        for (int i = 0; i < 10; i++) push("halt_hold", MR_IDLE, hv, strobe_mask());
        run_steps(-1);

        // Reset pulse exits HALT.
        rst_f = 1'b0;
        #1;
        check("halt_reset", 32'(cur_out()), 32'(rv));
        @(negedge clk);
        rst_f = 1'b1;

        // Reset asserted while a STORE sits in MEM aborts it.
        instr = 32'h4A30_0008;
        stat  = 4'h0;
        gen(instr, stat, 3, "st_abort");
        run_steps(3);
        mem_ready = 1'b0;
        #1;
        check("st_abort_mem_pre", 32'(mem_write), 32'h1);
        #2;
        rst_f = 1'b0;
        #1;
        check("st_abort_rst", 32'(cur_out()), 32'(rv));
        sb.delete();
        @(negedge clk);
        rst_f = 1'b1;
        do_instr(32'h0000_0000, 4'h0, 0, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
